// File: rtl/seq_arb_pkg.sv
// Shared types and helpers for the round-robin "101" detector arbiter.
package seq_arb_pkg;

  typedef enum logic [1:0] {IDLE, CLR, STREAM, DRAIN} state_t;

  typedef enum logic [1:0] {S00 = 2'b00, S01 = 2'b01, S10 = 2'b10, S11 = 2'b11} det_state_t;

  // First asserted request at or after ptr, wrapping at n (n <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0]  win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = (32'(ptr) + i) % n;
      if (i < n && !found && req[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/seq_det_arbiter_if.sv
// Requester-side bus of seq_det_arbiter: requests, serial data, grant and detection reporting.
interface seq_det_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       bit_in;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   det_pulse;
  logic [IDW-1:0]         det_id;
  logic [N_REQ*CNT_W-1:0] hit_cnt;
  logic                   abort;

  modport master (output req, bit_in,
                  input  gnt, busy, det_pulse, det_id, hit_cnt, abort);
  modport slave  (input  req, bit_in,
                  output gnt, busy, det_pulse, det_id, hit_cnt, abort);
endinterface

// File: rtl/seq_det_101.sv
// Moore overlapping "101" detector with enable and synchronous clear.
module seq_det_101
  import seq_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic w,
  output logic z
);
  det_state_t y, y_nxt;

  always_comb begin
    y_nxt = y;
    if (en) begin
      unique case (y)
        S00: y_nxt = w ? S01 : S00;
        S01: y_nxt = w ? S01 : S10;
        S10: y_nxt = w ? S11 : S00;
        S11: y_nxt = w ? S01 : S10;
        default: y_nxt = S00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     y <= S00;
    else if (clr) y <= S00;
    else          y <= y_nxt;
  end

  assign z = (y == S11);
endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter streaming BURST_LEN-bit bursts into one shared "101" detector.
// Define SEQ_ARB_FIXED_PRIO_EN for fixed priority (lowest asserted index wins).
module seq_det_arbiter
  import seq_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  seq_det_arbiter_if.slave bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [IDW-1:0]   sel, ptr, pick, ptr_nxt;
  logic [7:0]       beat;
  logic [N_REQ-1:0] gnt;
  logic             abort_q, fed;
  logic             det_clr, det_en, z, det_pulse;
  logic [CNT_W-1:0] cnt [N_REQ];

  assign det_clr   = (state == CLR);
  assign det_en    = (state == STREAM) && bus.req[sel];
  assign det_pulse = z & fed;
  // With the pointer pinned at 0, rr_pick degenerates to lowest-index priority.
  assign pick      = IDW'(rr_pick(8'(bus.req), 3'(ptr), N_REQ));
  assign ptr_nxt   = (sel == IDW'(N_REQ - 1)) ? '0 : sel + 1'b1;

  seq_det_101 u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .en  (det_en),
    .w   (bus.bit_in[sel]),
    .z   (z)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sel     <= '0;
      ptr     <= '0;
      beat    <= '0;
      gnt     <= '0;
      abort_q <= 1'b0;
      fed     <= 1'b0;
    end else begin
      fed     <= det_en;
      abort_q <= 1'b0;
      unique case (state)
        IDLE: if (|bus.req) begin
          sel   <= pick;
          gnt   <= N_REQ'(1) << pick;
          state <= CLR;
        end
        CLR: begin
          beat  <= '0;
          state <= STREAM;
        end
        STREAM: if (!bus.req[sel]) begin
          gnt     <= '0;
          abort_q <= 1'b1;
          state   <= DRAIN;
        end else begin
          beat <= beat + 1'b1;
          if (beat == 8'(BURST_LEN - 1)) begin
            gnt   <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
`ifdef SEQ_ARB_FIXED_PRIO_EN
          ptr <= '0;
`else
          ptr <= ptr_nxt;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else if (det_pulse && cnt[sel] != '1) begin
      cnt[sel] <= cnt[sel] + 1'b1;
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    assign bus.hit_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end

  assign bus.gnt       = gnt;
  assign bus.busy      = (state != IDLE);
  assign bus.det_pulse = det_pulse;
  assign bus.det_id    = sel;
  assign bus.abort     = abort_q;
endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed bench for seq_det_arbiter: a default instance plus a CNT_W=2 instance sharing stimulus.
module tb_seq_det_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] bit_in = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_det_arbiter_if #(.N_REQ(4), .CNT_W(8)) bus ();
  seq_det_arbiter_if #(.N_REQ(4), .CNT_W(2)) bus_sat ();

  assign bus.req        = req;
  assign bus.bit_in     = bit_in;
  assign bus_sat.req    = req;
  assign bus_sat.bit_in = bit_in;

  seq_det_arbiter #(.N_REQ(4), .BURST_LEN(8), .CNT_W(8)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  seq_det_arbiter #(.N_REQ(4), .BURST_LEN(8), .CNT_W(2)) dut_sat (
    .clk (clk), .rst (rst), .bus (bus_sat)
  );

`ifdef SEQ_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; bit_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Starts from IDLE at a negedge; feeds bits[k] in STREAM cycle k+1, drops req[lane] after nfeed bits.
  task automatic burst(input string tag, input int lane, input logic [3:0] req_on,
                       input logic [3:0] req_after, input logic [7:0] bits, input int nfeed,
                       input int exp_gnt, input int exp_busy, input logic [15:0] exp_mask,
                       input int exp_abort);
    int         gcyc = 0, bcyc = 0, abc = 0, idbad = 0;
    logic [15:0] mask = '0;
    logic [3:0]  g0 = '0;
    logic [3:0]  onehot;
    bit          done = 1'b0;
    onehot = 4'b0001 << lane;
    req = req_on; bit_in = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 0) g0 = bus.gnt;
      if (bus.busy) bcyc++; else done = 1'b1;
      if (bus.gnt != '0) gcyc++;
      if (bus.abort) abc++;
      if (bus.det_pulse) begin
        mask[c] = 1'b1;
        if (bus.det_id != 2'(lane)) idbad++;
      end
      if (done) begin
        req = req_after; bit_in = '0;
      end else if (c >= 1 && c <= 8) begin
        if (c - 1 < nfeed) bit_in[lane] = bits[c-1];
        else req[lane] = 1'b0;
      end
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_gnt"}, 32'(g0), 32'(onehot));
    check({tag, "_gnt_cycles"}, gcyc, exp_gnt);
    check({tag, "_busy_cycles"}, bcyc, exp_busy);
    check({tag, "_pulse_mask"}, 32'(mask), 32'(exp_mask));
    check({tag, "_det_id"}, idbad, 0);
    check({tag, "_abort"}, abc, exp_abort);
  endtask

  initial begin
    int ab;
    // reset values while held in reset
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_pulse", 32'(bus.det_pulse), 0);
    check("rst_det_id", 32'(bus.det_id), 0);
    check("rst_abort", 32'(bus.abort), 0);
    check("rst_hit", bus.hit_cnt, 0);
    rst = 1'b1;
    @(negedge clk);

    // single burst on lane 0: pulses after bits 3 and 5
    burst("single", 0, 4'b0001, 4'b0000, 8'b0001_0101, 8, 9, 10, 16'h0050, 0);
    check("single_hit", bus.hit_cnt, 32'h0000_0002);
    check("single_hit_sat", 32'(bus_sat.hit_cnt), 32'h02);

    // asynchronous reset in the middle of a burst
    req = 4'b0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    check("async_gnt", 32'(bus.gnt), 0);
    check("async_busy", 32'(bus.busy), 0);
    check("async_hit", bus.hit_cnt, 0);
    check("async_hit_sat", 32'(bus_sat.hit_cnt), 0);
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    ab = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.abort) ab++;
    end
    check("post_rst_abort", ab, 0);
    check("post_rst_busy", 32'(bus.busy), 0);

    // round-robin with all lanes requesting
    do_reset();
    for (int i = 0; i < 5; i++)
      burst($sformatf("rr%0d", i), FIXED ? 0 : i % 4, 4'b1111, 4'b1111, 8'h00, 8, 9, 10, 16'h0, 0);

    // early end on lane 2, then lane 3 is next in rotation
    do_reset();
    burst("abort", 2, 4'b0100, 4'b1100, 8'b0000_1101, 4, 6, 7, 16'h0010, 1);
    check("abort_hit", bus.hit_cnt, 32'h0001_0000);
    burst("after_abort", FIXED ? 2 : 3, 4'b1100, 4'b0000, 8'h00, 8, 9, 10, 16'h0, 0);

    // lane 0 leaves detector at "10"; lane 1 starting with 1 must not hit
    do_reset();
    burst("iso0", 0, 4'b0001, 4'b0010, 8'b0100_0000, 8, 9, 10, 16'h0, 0);
    burst("iso1", 1, 4'b0010, 4'b0000, 8'b0000_0001, 8, 9, 10, 16'h0, 0);
    check("iso_hit", bus.hit_cnt, 0);

    // four detections on lane 1: 8-bit counter reaches 4, 2-bit counter sticks at 3
    do_reset();
    burst("sat_a", 1, 4'b0010, 4'b0010, 8'b0101_0101, 8, 9, 10, 16'h0150, 0);
    burst("sat_b", 1, 4'b0010, 4'b0000, 8'b0000_0101, 8, 9, 10, 16'h0010, 0);
    check("sat_hit8", bus.hit_cnt, 32'h0000_0400);
    check("sat_hit2", 32'(bus_sat.hit_cnt), 32'h0C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
